// File: rtl/haar_pkg.sv
// Shared widths, FSM state encoding and the saturating add used by the Haar weak classifier.
package haar_pkg;

    localparam int unsigned DefDataW    = 16;
    localparam int unsigned DefWeightW  = 16;
    localparam int unsigned DefAccW     = 40;
    localparam int unsigned DefNodeW    = 16;
    localparam int unsigned DefMaxRects = 3;

    // Working width of sat_add; accumulators up to SatW-1 bits are supported.
    localparam int unsigned SatW = 64;

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

    typedef struct packed {
        logic            sat;
        logic [SatW-1:0] sum;
    } sat_res_t;

    // Adds two sign-extended operands and clamps the result to a signed 'width'-bit range.
    function automatic sat_res_t sat_add(input logic signed [SatW-1:0] acc,
                                         input logic signed [SatW-1:0] prod,
                                         input int unsigned            width);
        logic signed [SatW:0] full;
        logic signed [SatW:0] max_v;
        logic signed [SatW:0] min_v;
        sat_res_t             res;
        full  = {acc[SatW-1], acc} + {prod[SatW-1], prod};
        max_v = '0;
        max_v[width-1] = 1'b1;
        max_v = max_v - 1;
        min_v = -max_v - 1;
        res.sat = 1'b0;
        res.sum = full[SatW-1:0];
        if (full > max_v) begin
            res.sat = 1'b1;
            res.sum = max_v[SatW-1:0];
        end else if (full < min_v) begin
            res.sat = 1'b1;
            res.sum = min_v[SatW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/haar_rect_mac.sv
// Stages 1-2: combine four integral-image corners into a rectangle sum, then weight it.
module haar_rect_mac #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WEIGHT_W = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [DATA_W-1:0]                  in_a,
    input  logic [DATA_W-1:0]                  in_b,
    input  logic [DATA_W-1:0]                  in_c,
    input  logic [DATA_W-1:0]                  in_d,
    input  logic [WEIGHT_W-1:0]                in_weight,
    output logic                               out_valid,
    output logic signed [DATA_W+WEIGHT_W+1:0]  out_prod
);

    localparam int unsigned RectW = DATA_W + 2;
    localparam int unsigned ProdW = RectW + WEIGHT_W;

    logic signed [RectW-1:0]    rect_d;
    logic signed [RectW-1:0]    rect_q;
    logic signed [WEIGHT_W-1:0] weight_q;
    logic                       v1_q;
    logic                       v2_q;
    logic signed [ProdW-1:0]    prod_q;

    // Two guard bits keep (a+d)-(b+c) exact for any corner values.
    always_comb begin
        rect_d = $signed({2'b00, in_a}) + $signed({2'b00, in_d})
               - $signed({2'b00, in_b}) - $signed({2'b00, in_c});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            rect_q   <= '0;
            weight_q <= '0;
            prod_q   <= '0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (in_valid) begin
                rect_q   <= rect_d;
                weight_q <= in_weight;
            end
            if (v1_q) begin
                prod_q <= $signed({{WEIGHT_W{rect_q[RectW-1]}}, rect_q})
                        * $signed({{RectW{weight_q[WEIGHT_W-1]}}, weight_q});
            end
        end
    end

    assign out_valid = v2_q;
    assign out_prod  = prod_q;

endmodule

// File: rtl/haar_weak_classifier_seq.sv
// Serial-beat Haar weak classifier: accumulates weighted rectangles, thresholds, returns a leaf.
module haar_weak_classifier_seq
    import haar_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned WEIGHT_W  = DefWeightW,
    parameter int unsigned ACC_W     = DefAccW,
    parameter int unsigned NODE_W    = DefNodeW,
    parameter int unsigned MAX_RECTS = DefMaxRects
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_d,
    input  logic [WEIGHT_W-1:0] in_weight,
    input  logic              in_last,
    input  logic [ACC_W-1:0]  in_threshold,
    input  logic [NODE_W-1:0] in_left,
    input  logic [NODE_W-1:0] in_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NODE_W-1:0] out_value,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat,
    output logic              out_err
);

    localparam int unsigned ProdW = DATA_W + 2 + WEIGHT_W;
    localparam int unsigned CntW  = $clog2(MAX_RECTS + 1);

    state_e                  state_q;
    logic [1:0]              drain_q;
    logic [CntW-1:0]         cnt_q;
    logic                    sat_q;
    logic                    err_q;
    logic signed [SatW-1:0]  acc_q;
    logic [ACC_W-1:0]        thr_q;
    logic [NODE_W-1:0]       left_q;
    logic [NODE_W-1:0]       right_q;

    logic                    beat;
    logic                    acc_beat;
    logic                    prod_valid;
    logic signed [ProdW-1:0] prod;
    logic signed [SatW-1:0]  prod_ext;
    logic signed [SatW-1:0]  thr_ext;
    sat_res_t                add_res;

    assign in_ready = (state_q == StIdle) || (state_q == StAccum);
    assign beat     = in_valid && in_ready && !flush;
    // Beats past MAX_RECTS still advance the protocol but never reach the multiplier.
    assign acc_beat = beat && (cnt_q < CntW'(MAX_RECTS));

    assign prod_ext = {{(SatW - ProdW){prod[ProdW-1]}}, prod};
    assign thr_ext  = {{(SatW - ACC_W){thr_q[ACC_W-1]}}, thr_q};
    assign add_res  = sat_add(acc_q, prod_ext, ACC_W);

    haar_rect_mac #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (acc_beat),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .in_weight (in_weight),
        .out_valid (prod_valid),
        .out_prod  (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            drain_q   <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            thr_q     <= '0;
            left_q    <= '0;
            right_q   <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
        end else if (flush) begin
            state_q   <= StIdle;
            drain_q   <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (beat) begin
                if (state_q == StIdle) begin
                    thr_q   <= in_threshold;
                    left_q  <= in_left;
                    right_q <= in_right;
                end
                if (acc_beat) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (prod_valid) begin
                acc_q <= $signed(add_res.sum);
                if (add_res.sat) begin
                    sat_q <= 1'b1;
                end
            end
            unique case (state_q)
                StIdle, StAccum: begin
                    if (beat) begin
                        state_q <= in_last ? StDrain : StAccum;
                        drain_q <= '0;
                    end
                end
                StDrain: begin
                    // Third cycle: the last product has been folded into acc_q.
                    if (drain_q == 2'd2) begin
                        state_q   <= StHold;
                        out_valid <= 1'b1;
                        out_sum   <= acc_q[ACC_W-1:0];
                        out_value <= (acc_q < thr_ext) ? left_q : right_q;
                        out_sat   <= sat_q;
                        out_err   <= err_q;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        sat_q     <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_haar_weak_classifier_seq.sv
// Directed bench for haar_weak_classifier_seq with a narrow accumulator so overflow is reachable.
module tb_haar_weak_classifier_seq;

    localparam int unsigned AccW = 34;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_a, in_b, in_c, in_d, in_weight;
    logic            in_last;
    logic [AccW-1:0] in_threshold;
    logic [15:0]     in_left, in_right;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_value;
    logic [AccW-1:0] out_sum;
    logic            out_sat;
    logic            out_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    logic [AccW-1:0] exp_sum;

    always #5 clk = ~clk;

    haar_weak_classifier_seq #(
        .DATA_W    (16),
        .WEIGHT_W  (16),
        .ACC_W     (AccW),
        .NODE_W    (16),
        .MAX_RECTS (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_c         (in_c),
        .in_d         (in_d),
        .in_weight    (in_weight),
        .in_last      (in_last),
        .in_threshold (in_threshold),
        .in_left      (in_left),
        .in_right     (in_right),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_sum      (out_sum),
        .out_sat      (out_sat),
        .out_err      (out_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input logic [15:0] w, input logic last,
                        input logic [AccW-1:0] thr, input logic [15:0] l, input logic [15:0] r);
        in_a = a; in_b = b; in_c = c; in_d = d; in_weight = w; in_last = last;
        in_threshold = thr; in_left = l; in_right = r; in_valid = 1'b1;
        check("beat_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("accept_in_ready", in_ready, 1);
        check("accept_out_valid", out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_weight = '0; in_last = 1'b0;
        in_threshold = '0; in_left = '0; in_right = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_err", out_err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 10*1 + (-4)*2 + 3*(-1) = -1 < 0 -> left
        beat(16'd10, 16'd0, 16'd0, 16'd0, 16'd1, 1'b0, '0, 16'h11, 16'h22);
        beat(16'd0, 16'd4, 16'd0, 16'd0, 16'd2, 1'b0, '0, 16'h99, 16'h99);
        beat(16'd3, 16'd0, 16'd0, 16'd0, 16'hFFFF, 1'b1, '0, 16'h99, 16'h99);
        wait_valid(cyc);
        check("t1_latency", cyc, 3);
        exp_sum = '1;
        check("t1_sum", out_sum, exp_sum);
        check("t1_value", out_value, 16'h11);
        check("t1_sat", out_sat, 0);
        check("t1_err", out_err, 0);
        check("t1_hold_in_ready", in_ready, 0);
        accept();

        // single beat, 5*3 = 15, not < 15 -> right
        beat(16'd5, 16'd0, 16'd0, 16'd0, 16'd3, 1'b1, AccW'(15), 16'hAA, 16'hBB);
        check("t2_drain_in_ready", in_ready, 0);
        wait_valid(cyc);
        check("t2_latency", cyc, 3);
        check("t2_sum", out_sum, 15);
        check("t2_value", out_value, 16'hBB);
        accept();

        // 4 beats: 1+2+3, fourth (100) dropped, err set
        beat(16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 1'b0, '0, 16'h55, 16'h66);
        beat(16'd2, 16'd0, 16'd0, 16'd0, 16'd1, 1'b0, '0, 16'h55, 16'h66);
        beat(16'd3, 16'd0, 16'd0, 16'd0, 16'd1, 1'b0, '0, 16'h55, 16'h66);
        beat(16'd100, 16'd0, 16'd0, 16'd0, 16'd1, 1'b1, '0, 16'h55, 16'h66);
        wait_valid(cyc);
        check("t3_latency", cyc, 3);
        check("t3_sum", out_sum, 6);
        check("t3_value", out_value, 16'h66);
        check("t3_err", out_err, 1);
        check("t3_sat", out_sat, 0);
        accept();

        // 3 x (-131070 * -32768) overflows a 34-bit accumulator
        for (int i = 0; i < 3; i++) begin
            beat(16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'h8000, (i == 2), '0, 16'h77, 16'h88);
        end
        wait_valid(cyc);
        check("t4_latency", cyc, 3);
        exp_sum = {1'b0, {(AccW - 1){1'b1}}};
        check("t4_sum", out_sum, exp_sum);
        check("t4_sat", out_sat, 1);
        check("t4_value", out_value, 16'h88);

        // stall in HOLD with a beat offered that must not be taken
        in_a = 16'd500; in_weight = 16'd1; in_last = 1'b1; in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("t5_valid", out_valid, 1);
        check("t5_sum", out_sum, exp_sum);
        check("t5_sat", out_sat, 1);
        check("t5_value", out_value, 16'h88);
        check("t5_in_ready", in_ready, 0);
        accept();
        beat(16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 1'b1, '0, 16'h01, 16'h02);
        wait_valid(cyc);
        check("t5_next_sum", out_sum, 1);
        check("t5_next_sat", out_sat, 0);
        accept();

        // flush after 2 large beats; flush-cycle beat discarded
        beat(16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'h8000, 1'b0, '0, 16'h01, 16'h02);
        beat(16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'h8000, 1'b0, '0, 16'h01, 16'h02);
        in_a = 16'd50; in_weight = 16'd1; in_last = 1'b1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
        check("t6_flush_in_ready", in_ready, 1);
        check("t6_flush_out_valid", out_valid, 0);
        beat(16'd7, 16'd0, 16'd0, 16'd0, 16'd2, 1'b1, AccW'(100), 16'h33, 16'h44);
        wait_valid(cyc);
        check("t6_latency", cyc, 3);
        check("t6_sum", out_sum, 14);
        check("t6_value", out_value, 16'h33);
        check("t6_sat", out_sat, 0);
        check("t6_err", out_err, 0);
        accept();

        // async reset while draining
        beat(16'd2, 16'd0, 16'd0, 16'd0, 16'd2, 1'b1, '0, 16'h01, 16'h02);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t7_in_ready", in_ready, 1);
        check("t7_out_valid", out_valid, 0);
        check("t7_out_value", out_value, 0);
        check("t7_out_sum", out_sum, 0);
        check("t7_out_sat", out_sat, 0);
        check("t7_out_err", out_err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        beat(16'd9, 16'd0, 16'd0, 16'd0, 16'd1, 1'b1, '0, 16'h01, 16'h02);
        wait_valid(cyc);
        check("t7_after_sum", out_sum, 9);
        check("t7_after_value", out_value, 16'h02);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
